// File: rtl/axi_dslv_pkg.sv
// Shared types and constants for the AXI default (terminating) slave.
package axi_dslv_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_default_slave.sv
// Terminating AXI slave: answers every transaction with DECERR and zero read data.
// Define DEFAULT_SLAVE_ERRLOG_EN to add the err_addr / err_is_wr / err_cnt access log.
module axi_default_slave
    import axi_dslv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDS_W  = 8,
    parameter int LEN_W  = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [IDS_W-1:0]    AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [IDS_W-1:0]    BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [IDS_W-1:0]    ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [LEN_W-1:0]    ARLEN,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [IDS_W-1:0]    RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
`ifdef DEFAULT_SLAVE_ERRLOG_EN
    ,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                err_is_wr,
    output logic [15:0]         err_cnt
`endif
);

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;

    logic [IDS_W-1:0] bid_reg;
    logic [LEN_W-1:0] awlen_reg;
    logic [IDS_W-1:0] rid_reg;
    logic [LEN_W-1:0] arlen_reg;
    logic [LEN_W-1:0] cnt_reg;

    logic aw_hs, w_hs, ar_hs, r_hs;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID  && RREADY;

    // ---------------- write channel ----------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) w_state_next = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                // Burst ends on WLAST alone; the latched AWLEN is not trusted.
                if (WVALID && WLAST) w_state_next = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            bid_reg   <= '0;
            awlen_reg <= '0;
        end else if (aw_hs) begin
            bid_reg   <= AWID;
            awlen_reg <= AWLEN;
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        RLAST        = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) r_state_next = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = (cnt_reg == arlen_reg);
                if (RREADY && (cnt_reg == arlen_reg)) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Completion at cnt==len means the counter never needs to wrap.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rid_reg   <= '0;
            arlen_reg <= '0;
            cnt_reg   <= '0;
        end else if (ar_hs) begin
            rid_reg   <= ARID;
            arlen_reg <= ARLEN;
            cnt_reg   <= '0;
        end else if (r_hs && !RLAST) begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    assign BID   = bid_reg;
    assign BRESP = RESP_DECERR;
    assign RID   = rid_reg;
    assign RDATA = '0;
    assign RRESP = RESP_DECERR;

`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [ADDR_W-1:0] err_addr_reg;
    logic              err_is_wr_reg;
    logic [15:0]       err_cnt_reg;
    logic [16:0]       cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, err_cnt_reg} + 17'(aw_hs) + 17'(ar_hs);
    end

    // A simultaneous AW and AR logs the write address.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_addr_reg  <= '0;
            err_is_wr_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (aw_hs) begin
                err_addr_reg  <= AWADDR;
                err_is_wr_reg <= 1'b1;
            end else if (ar_hs) begin
                err_addr_reg  <= ARADDR;
                err_is_wr_reg <= 1'b0;
            end
            if (aw_hs || ar_hs) begin
                err_cnt_reg <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            end
        end
    end

    assign err_addr  = err_addr_reg;
    assign err_is_wr = err_is_wr_reg;
    assign err_cnt   = err_cnt_reg;

    logic unused_inputs;
    assign unused_inputs = ^{WDATA, WSTRB, awlen_reg, w_hs};
`else
    logic unused_inputs;
    assign unused_inputs = ^{WDATA, WSTRB, awlen_reg, w_hs, AWADDR, ARADDR};
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Self-checking bench for axi_default_slave: directed protocol cases plus randomized bursts.
module tb_axi_default_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [31:0] err_addr;
    logic        err_is_wr;
    logic [15:0] err_cnt;
`endif

    axi_default_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        , .err_addr(err_addr), .err_is_wr(err_is_wr), .err_cnt(err_cnt)
`endif
    );

    always #5 ACLK = ~ACLK;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: outstanding B responses, outstanding R beats (RLAST flag per beat),
    // and the expected access log.
    logic [7:0]  exp_b[$];
    logic        exp_r[$];
    logic [31:0] exp_err_addr = '0;
    logic        exp_err_wr   = 1'b0;
    int          exp_err_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic note_access(input logic [31:0] addr, input logic wr, input int n);
        exp_err_addr = addr;
        exp_err_wr   = wr;
        exp_err_cnt  = (exp_err_cnt + n > 65535) ? 65535 : exp_err_cnt + n;
    endtask

    task automatic model_reset();
        exp_b.delete();
        exp_r.delete();
        exp_err_addr = '0;
        exp_err_wr   = 1'b0;
        exp_err_cnt  = 0;
    endtask

    task automatic chk_log();
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        chk("err_addr", err_addr, exp_err_addr);
        chk("err_is_wr", err_is_wr, exp_err_wr);
        chk("err_cnt", err_cnt, exp_err_cnt);
`endif
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input int nbeats, input int bstall, input bit wgap);
        logic [7:0] exp_id;
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        chk("aw_ready_idle", AWREADY, 1'b1);
        tick();
        AWVALID = 1'b0;
        exp_b.push_back(id);
        note_access(addr, 1'b1, 1);
        chk("aw_ready_busy", AWREADY, 1'b0);
        chk("w_ready_data", WREADY, 1'b1);
        chk("b_valid_after_aw", BVALID, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            if (wgap && ($urandom_range(0, 1) == 1)) begin
                WVALID = 1'b0;
                tick();
                chk("w_ready_gap", WREADY, 1'b1);
                chk("b_valid_gap", BVALID, 1'b0);
            end
            WVALID = 1'b1;
            WLAST  = (i == nbeats - 1);
            WDATA  = $urandom;
            WSTRB  = 4'($urandom);
            tick();
            if (i != nbeats - 1) chk("b_valid_early", BVALID, 1'b0);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        exp_id = exp_b.pop_front();
        for (int s = 0; s <= bstall; s++) begin
            BREADY = (s == bstall);
            chk("b_valid", BVALID, 1'b1);
            chk("b_id", BID, exp_id);
            chk("b_resp", BRESP, 2'b11);
            chk("w_ready_resp", WREADY, 1'b0);
            chk("aw_ready_resp", AWREADY, 1'b0);
            tick();
        end
        BREADY = 1'b0;
        chk("b_valid_done", BVALID, 1'b0);
        chk("aw_ready_after", AWREADY, 1'b1);
        chk_log();
        $display("write id=%02h addr=%08h awlen=%0d beats=%0d bstall=%0d", id, addr, len, nbeats, bstall);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int first_stall, input int stall_pct);
        int cyc;
        logic popped;
        ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        chk("ar_ready_idle", ARREADY, 1'b1);
        tick();
        ARVALID = 1'b0;
        note_access(addr, 1'b0, 1);
        for (int b = 0; b <= int'(len); b++) exp_r.push_back(b == int'(len));
        cyc = 0;
        while (exp_r.size() > 0 && cyc < 300) begin
            RREADY = (cyc >= first_stall) && ($urandom_range(0, 99) >= stall_pct);
            chk("r_valid", RVALID, 1'b1);
            chk("r_id", RID, id);
            chk("r_last", RLAST, exp_r[0]);
            chk("r_data", RDATA, 32'h0);
            chk("r_resp", RRESP, 2'b11);
            chk("ar_ready_busy", ARREADY, 1'b0);
            tick();
            cyc++;
            if (RREADY) popped = exp_r.pop_front();
        end
        RREADY = 1'b0;
        chk("r_beats_budget", exp_r.size(), 0);
        exp_r.delete();
        chk("r_valid_done", RVALID, 1'b0);
        chk("ar_ready_after", ARREADY, 1'b1);
        chk_log();
        $display("read  id=%02h addr=%08h arlen=%0d cycles=%0d", id, addr, len, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", AWREADY, 1'b1);
        chk("rst_arready", ARREADY, 1'b1);
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_rlast", RLAST, 1'b0);
        chk("rst_bid", BID, 8'h00);
        chk("rst_rid", RID, 8'h00);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_bresp", BRESP, 2'b11);
        chk("rst_rresp", RRESP, 2'b11);
        chk_log();
        @(negedge ACLK);
        ARESET = 1'b0;
        $display("reset released");

        // Concurrent AW and AR in one cycle.
        AWID = 8'h21; AWADDR = 32'hA000_0010; AWLEN = 4'd0; AWVALID = 1'b1;
        ARID = 8'h22; ARADDR = 32'hB000_0020; ARLEN = 4'd0; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        note_access(32'hA000_0010, 1'b1, 2);
        chk("conc_awready", AWREADY, 1'b0);
        chk("conc_arready", ARREADY, 1'b0);
        chk("conc_wready", WREADY, 1'b1);
        chk("conc_rvalid", RVALID, 1'b1);
        chk("conc_rlast", RLAST, 1'b1);
        chk("conc_rid", RID, 8'h22);
        chk_log();
        WVALID = 1'b1; WLAST = 1'b1; RREADY = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0;
        chk("conc_bvalid", BVALID, 1'b1);
        chk("conc_bid", BID, 8'h21);
        chk("conc_rvalid_done", RVALID, 1'b0);
        chk("conc_arready_after", ARREADY, 1'b1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("conc_bvalid_done", BVALID, 1'b0);
        chk("conc_awready_after", AWREADY, 1'b1);
        $display("concurrent AW+AR done");

        // WVALID before the AW handshake must not be consumed.
        WVALID = 1'b1; WLAST = 1'b1;
        tick();
        tick();
        chk("early_w_wready", WREADY, 1'b0);
        chk("early_w_bvalid", BVALID, 1'b0);
        do_write(8'h12, 32'h4000_0000, 4'd0, 1, 0, 1'b0);

        do_write(8'h34, 32'h4000_1000, 4'd3, 4, 5, 1'b0);
        do_write(8'h56, 32'h4000_2000, 4'd0, 3, 1, 1'b0);
        do_read(8'h05, 32'h5000_0000, 4'd3, 0, 0);
        do_read(8'h06, 32'h5000_0100, 4'd1, 5, 0);
        do_read(8'h07, 32'h5000_0200, 4'd15, 0, 0);

        // Reset in the middle of a read burst.
        ARID = 8'h33; ARADDR = 32'h6000_0000; ARLEN = 4'd7; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        chk("mid_rvalid_b1", RVALID, 1'b1);
        tick();
        chk("mid_rvalid_b2", RVALID, 1'b1);
        chk("mid_rlast_b2", RLAST, 1'b0);
        #2;
        ARESET = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_rvalid", RVALID, 1'b0);
        chk("mid_rst_arready", ARREADY, 1'b1);
        chk("mid_rst_rid", RID, 8'h00);
        RREADY = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        chk_log();
        $display("reset mid-burst done");
        do_read(8'h44, 32'h6000_0040, 4'd0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            do_write(8'($urandom), $urandom, 4'($urandom), $urandom_range(1, 5),
                     $urandom_range(0, 3), 1'b1);
            do_read(8'($urandom), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                    $urandom_range(0, 50));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
